interrupt_ctrl: RTL

//  Collects interrupt sources (timers, external pin) and latches each into a pending bit.

---
 rtl/bridge_pkg.sv | 30 +++
 rtl/int_prio_enc.sv | 19 +
 rtl/interrupt_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared constants for the system bridge: interrupt controller address map,
// register offsets and the external-interrupt acknowledge state encoding.
package bridge_pkg;

    localparam int          NSRC_DEF      = 6;
    localparam logic [5:0]  EDGE_MASK_DEF = 6'b000100;
    localparam int          EXT_BIT_DEF   = 2;

    localparam logic [31:0] ACK_ADDR_DEF  = 32'h0000_7f20;
    localparam logic [31:0] CFG_BASE_DEF  = 32'h0000_7f40;

    // Register offsets inside the four-word configuration block
    localparam logic [31:0] OFF_MASK      = 32'h0000_0000;
    localparam logic [31:0] OFF_PENDING   = 32'h0000_0004;
    localparam logic [31:0] OFF_CLEAR     = 32'h0000_0008;
    localparam logic [31:0] OFF_ID        = 32'h0000_000c;

    localparam logic [31:0] WORD_MASK     = 32'hffff_fffc;

    // External-interrupt acknowledge states
    localparam logic [1:0]  EXT_IDLE      = 2'd0;
    localparam logic [1:0]  EXT_PEND      = 2'd1;
    localparam logic [1:0]  EXT_WAITLO    = 2'd2;

    // Word-align an address; byte offsets never select a different register
    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Priority encoder: index of the lowest-numbered set request, 7 when none.
module int_prio_enc #(
    parameter int N = 6
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx
);

    // Scan from the top down so the lowest set bit is written last and wins
    always_comb begin
        idx = 3'd7;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[2:0];
            end
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: latches timer/external sources into pending bits,
// masks them onto hw_int for CP0, and retires requests through CPU stores
// (CLEAR register or the external-interrupt acknowledge address).
//
// Bus handshake: there is no valid/ready; a store is present in any cycle
// where m_int_byteen != 0 and is always accepted in that same cycle. Loads
// are combinational from rd_addr and have no side effects.
module interrupt_ctrl
    import bridge_pkg::*;
#(
    parameter int                NSRC      = NSRC_DEF,
    parameter logic [NSRC-1:0]   EDGE_MASK = EDGE_MASK_DEF,
    parameter int                EXT_BIT   = EXT_BIT_DEF,
    parameter logic [31:0]       ACK_ADDR  = ACK_ADDR_DEF,
    parameter logic [31:0]       CFG_BASE  = CFG_BASE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC-1:0]      irq_src,
    input  logic [31:0]          m_int_addr,
    input  logic [3:0]           m_int_byteen,
    input  logic [31:0]          m_int_wdata,
    input  logic [31:0]          rd_addr,
    output logic [31:0]          rd_data,
    output logic [NSRC-1:0]      hw_int,
    output logic [2:0]           irq_id,
    output logic                 ack_pulse,
    output logic [1:0]           ext_state
);

    logic [NSRC-1:0] src_q, src_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [1:0]      ext_q, ext_d;
    logic            ack_q, ack_d;

    logic [31:0]     wr_word;
    logic            wr_mask;
    logic            wr_clear;
    logic            ack_store;
    logic [NSRC-1:0] clr_bits;
    logic [NSRC-1:0] rise;

    // Only byte 0 of the write data carries register bits
    logic            unused_wdata;
    assign unused_wdata = ^m_int_wdata[31:NSRC];

    // Store decode: register writes need byte lane 0, the acknowledge needs any lane
    always_comb begin
        wr_word   = word_of(m_int_addr);
        wr_mask   = m_int_byteen[0] && (wr_word == CFG_BASE + OFF_MASK);
        wr_clear  = m_int_byteen[0] && (wr_word == CFG_BASE + OFF_CLEAR);
        ack_store = (m_int_byteen != 4'h0) && (wr_word == ACK_ADDR);
        clr_bits  = wr_clear ? m_int_wdata[NSRC-1:0] : '0;
        rise      = irq_src & ~src_q;
        src_d     = irq_src;
        mask_d    = wr_mask ? m_int_wdata[NSRC-1:0] : mask_q;
    end

    // External pin: latch on rise, retire by ack or CLEAR, re-arm only after the pin drops
    always_comb begin
        ext_d = ext_q;
        ack_d = 1'b0;
        case (ext_q)
            EXT_IDLE: begin
                if (rise[EXT_BIT]) begin
                    ext_d = EXT_PEND;
                end
            end
            EXT_PEND: begin
                if (ack_store) begin
                    ext_d = EXT_WAITLO;
                    ack_d = 1'b1;
                end else if (clr_bits[EXT_BIT]) begin
                    ext_d = EXT_WAITLO;
                end
            end
            EXT_WAITLO: begin
                if (!irq_src[EXT_BIT]) begin
                    ext_d = EXT_IDLE;
                end
            end
            default: ext_d = EXT_IDLE;
        endcase
    end

    // Pending update: level bits follow the pin, edge bits set-wins-over-clear
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NSRC; i++) begin
            if (i == EXT_BIT) begin
                pending_d[i] = (ext_d == EXT_PEND);
            end else if (EDGE_MASK[i]) begin
                pending_d[i] = rise[i] | (pending_q[i] & ~clr_bits[i]);
            end else begin
                pending_d[i] = irq_src[i];
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            ext_q     <= EXT_IDLE;
            ack_q     <= 1'b0;
        end else begin
            src_q     <= src_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ext_q     <= ext_d;
            ack_q     <= ack_d;
        end
    end

    assign hw_int    = pending_q & mask_q;
    assign ack_pulse = ack_q;
    assign ext_state = ext_q;

    int_prio_enc #(
        .N   (NSRC)
    ) u_prio (
        .req (hw_int),
        .idx (irq_id)
    );

    // Combinational register read; PENDING shows the value before any same-cycle CLEAR
    always_comb begin
        rd_data = '0;
        case (word_of(rd_addr))
            CFG_BASE + OFF_MASK:    rd_data[NSRC-1:0] = mask_q;
            CFG_BASE + OFF_PENDING: rd_data[NSRC-1:0] = pending_q;
            CFG_BASE + OFF_ID:      rd_data[2:0]      = irq_id;
            default:                rd_data           = '0;
        endcase
    end

endmodule
